// File: rtl/qsfp_link_monitor_pkg.sv
// qsfp_link_monitor_pkg: link FSM encodings and counter widths for the QSFP link monitor
package qsfp_link_monitor_pkg;
  localparam int DC_W = 16;
  typedef enum logic [1:0] {
    DOWN      = 2'd0,
    UP_PEND   = 2'd1,
    UP        = 2'd2,
    DOWN_PEND = 2'd3
  } link_state_t;
  function automatic logic is_up(link_state_t s);
    return s == UP || s == DOWN_PEND;
  endfunction
endpackage

// File: rtl/qsfp_link_monitor_cdc_single.sv
// cdc_single: two-flop synchronizer for a single asynchronous level
module cdc_single (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else        {q, meta} <= {meta, d};
endmodule

// File: rtl/qsfp_link_monitor.sv
// qsfp_link_monitor: debounced QSFP channel-up status with down-event and uptime counters
module qsfp_link_monitor
  import qsfp_link_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int UPTIME_W        = 32
) (
  input  logic                axi_clk,
  input  logic                axi_resetn,
  input  logic                channel_up_async,
  input  logic                clear_counts,
  output logic                link_up,
  output logic                link_change,
  output logic [DC_W-1:0]     down_count,
  output logic [UPTIME_W-1:0] uptime
);
  localparam logic [15:0] STAB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  logic        sync_up;
  link_state_t state, state_nxt;
  logic [15:0] stab_cnt, stab_nxt;
  logic        done, link_up_nxt, down_inc, rise;
  cdc_single u_sync (
    .clk   (axi_clk),
    .rst_n (axi_resetn),
    .d     (channel_up_async),
    .q     (sync_up)
  );
  assign done = stab_cnt == STAB_LAST;
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    case (state)
      DOWN:      if (sync_up) begin state_nxt = UP_PEND; stab_nxt = '0; end
      UP_PEND:   if (!sync_up) state_nxt = DOWN;
                 else begin stab_nxt = stab_cnt + 16'd1; state_nxt = done ? UP : UP_PEND; end
      UP:        if (!sync_up) begin state_nxt = DOWN_PEND; stab_nxt = '0; end
      DOWN_PEND: if (sync_up) state_nxt = UP;
                 else begin stab_nxt = stab_cnt + 16'd1; state_nxt = done ? DOWN : DOWN_PEND; end
      default:   state_nxt = DOWN;
    endcase
  end
  // link_up is registered from the next state so it changes on the same edge as the FSM
  assign link_up_nxt = is_up(state_nxt);
  assign down_inc    = state == DOWN_PEND && state_nxt == DOWN;
  assign rise        = link_up_nxt && !link_up;
  always_ff @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      state       <= DOWN;
      stab_cnt    <= '0;
      link_up     <= 1'b0;
      link_change <= 1'b0;
      down_count  <= '0;
      uptime      <= '0;
    end else begin
      state       <= state_nxt;
      stab_cnt    <= stab_nxt;
      link_up     <= link_up_nxt;
      link_change <= link_up_nxt ^ link_up;
      if (clear_counts || down_inc)
        down_count <= clear_counts ? DC_W'(down_inc) : down_count + DC_W'(~&down_count);
      if (rise) uptime <= '0;
      else if (link_up && !(&uptime)) uptime <= uptime + UPTIME_W'(1);
    end
endmodule

// File: doc/qsfp_link_monitor.md
QSFP_LINK_MONITOR -- requirements
Module: qsfp_link_monitor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, is the number of consecutive stable synchronized cycles required to change link state; legal range 2..65535.
REQ-002 Parameter UPTIME_W, default 32, is the width of the uptime counter.
REQ-003 axi_clk  in  1  sole clock; every flop is in this domain.
REQ-004 axi_resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 channel_up_async  in  1  raw channel-up from the QSFP/Aurora core, asynchronous to axi_clk.
REQ-006 clear_counts  in  1  single-cycle pulse that zeroes down_count.
REQ-007 link_up  out  1  debounced link status; feeds the status register block's channel-up input.
REQ-008 link_change  out  1  one-cycle pulse on every link_up transition.
REQ-009 down_count  out  16  number of debounced up->down transitions, saturating.
REQ-010 uptime  out  UPTIME_W  cycles elapsed since link_up last rose, saturating.

Function
REQ-011 channel_up_async SHALL pass through a 2-flop synchronizer; the output is sync_up, and synchronizer latency is 2 edges.
REQ-012 The FSM SHALL have the states DOWN, UP_PEND, UP and DOWN_PEND, with a 16-bit stability counter stab_cnt.
REQ-013 In DOWN, sync_up=1 SHALL move the FSM to UP_PEND with stab_cnt<=0.
REQ-014 In UP_PEND, sync_up=0 SHALL return the FSM to DOWN; otherwise stab_cnt SHALL increment, and when stab_cnt==DEBOUNCE_CYCLES-1 the FSM SHALL move to UP.
REQ-015 In UP, sync_up=0 SHALL move the FSM to DOWN_PEND with stab_cnt<=0.
REQ-016 In DOWN_PEND, sync_up=1 SHALL return the FSM to UP with no pulse and no count; otherwise stab_cnt SHALL increment, and when stab_cnt==DEBOUNCE_CYCLES-1 the FSM SHALL move to DOWN.
REQ-017 link_up SHALL be registered and equal 1 exactly in states UP and DOWN_PEND.
REQ-018 With channel_up_async held stable, link_up SHALL change exactly 2+DEBOUNCE_CYCLES+1 edges after the first edge that samples the new value.
REQ-019 link_change SHALL be 1 in the cycle in which link_up takes its new value, and 0 otherwise.
REQ-020 down_count SHALL increment by 1 on the UP/DOWN_PEND->DOWN transition and hold at 16'hFFFF.
REQ-021 When clear_counts coincides with an increment, down_count SHALL become 1; clear_counts alone SHALL give 0.
REQ-022 uptime SHALL load 0 in the cycle link_up rises, increment each cycle while link_up=1, and saturate at all-ones.
REQ-023 uptime SHALL hold its last value while link_up=0, and SHALL NOT be affected by clear_counts.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no link_up change, no pulse and no count change.

Reset
REQ-025 While axi_resetn=0, the block SHALL set: synchronizer flops 0, FSM DOWN, stab_cnt 0, link_up 0, link_change 0, down_count 0, uptime 0.
REQ-026 Reset asserted mid-debounce SHALL abandon the pending transition; after release the FSM SHALL restart from DOWN with no link_change pulse generated by reset.
REQ-027 The first rising edge after deassertion SHALL sample normally; no extra startup delay.

Structure
REQ-028 The FSM state encodings (DOWN=0, UP_PEND=1, UP=2, DOWN_PEND=3) and the down_count width SHALL live in the shared qsfp package.
REQ-029 Synchronization SHALL use the existing cdc_single sub-module, and no other sub-module SHALL be instantiated.
REQ-030 One instance SHALL exist per QSFP port; the two link_up outputs drive the status register block.

Verification (DEBOUNCE_CYCLES=8)
REQ-031 Scenario 1: reset, then channel_up_async 0->1 held -> link_up=1 with a link_change pulse 11 edges later, then uptime counts 0,1,2...
REQ-032 Scenario 2: link up, channel_up_async low for 5 cycles then high -> link_up stays 1, link_change never pulses, down_count stays 0.
REQ-033 Scenario 3: link up, channel_up_async low and held -> link_up=0 after 11 edges, down_count=1, uptime frozen.
REQ-034 Scenario 4: force down_count=16'hFFFE, then 3 full up/down cycles -> down_count ends at 16'hFFFF; then clear_counts -> 0; then clear_counts coincident with a down transition -> 1.
REQ-035 Scenario 5: axi_resetn pulsed low while in UP_PEND with stab_cnt=5 -> all outputs 0 immediately, no pulse; after release with input still high, link_up rises 11 edges later.
REQ-036 Scenario 6: UPTIME_W=4, link held up 20 cycles -> uptime saturates at 15 and holds.
